// File: rtl/initval_stim_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : initval_pkg                                                |
// | Description : Shared types, LFSR constants and helper for the initval   |
// |               nibble stimulus generator / response checker.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package initval_pkg;

   // One nibble of the DUT interface.
   typedef logic [3:0] nibble_t;

   // Checker run phases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WARM = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Feedback taps: new bit 0 is s[3] ^ s[2].
   localparam nibble_t LFSR_TAPS         = 4'b1100;
   localparam nibble_t LFSR_DEFAULT_SEED = 4'h9;

   // Left shift with the tapped XOR fed into bit 0 (period 15 for any nonzero seed).
   function automatic nibble_t lfsr4_next(input nibble_t s);
      return {s[2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage : initval_pkg
`default_nettype wire

// File: rtl/initval_stim_checker_lfsr4_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr4_gen                                                  |
// | Description : 4-bit Fibonacci-style LFSR with synchronous seed load and  |
// |               advance enable. Load has priority over advance.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lfsr4_gen
   import initval_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] seed,
   input  logic       adv,
   output logic [3:0] q
);

   logic [3:0] lfsr_q;
   logic [3:0] lfsr_d;

   // Next value: reload the seed, step the sequence, or hold.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = seed;
      end else if (adv) begin
         lfsr_d = lfsr4_next(lfsr_q);
      end
   end

   // State register; reset lands on the seed so a run can start immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule : lfsr4_gen
`default_nettype wire

// File: rtl/initval_stim_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : initval_stim_checker                                       |
// | Description : Drives an LFSR nibble stream on bar and checks the DUT's   |
// |               half-registered response foo == {bar_prev[3:2],bar[1:0]}. |
// |               Optional asdf check enabled by INITVAL_ASDF_CHECK_EN.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module initval_stim_checker
   import initval_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 16,
   parameter logic [3:0]  LFSR_SEED   = LFSR_DEFAULT_SEED,
   parameter int unsigned CNT_W       = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [3:0]       bar,
   input  logic [3:0]       foo,
   input  logic [3:0]       asdf,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_err_idx
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   state_t           state_q;
   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] err_q;
   logic [CNT_W-1:0] err_d;
   logic [CNT_W-1:0] first_q;
   logic [CNT_W-1:0] first_d;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [3:0]       bar_prev_q;
   logic [3:0]       lfsr_val;
   logic             lfsr_load;
   logic             lfsr_adv;
   logic             mismatch;

   // The seed is reloaded on every accepted start so each run replays the same vectors.
   assign lfsr_load = (state_q == IDLE) && start;
   assign lfsr_adv  = (state_q == WARM) || (state_q == RUN);

   lfsr4_gen u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .seed (LFSR_SEED),
      .adv  (lfsr_adv),
      .q    (lfsr_val)
   );

   // Outside WARM/RUN the stimulus is parked at zero.
   assign bar = busy_q ? lfsr_val : 4'h0;

   // Response compare; case-inequality so any X/Z on the DUT side is an error.
   always_comb begin
      mismatch = (foo !== {bar_prev_q[3:2], bar[1:0]});
`ifdef INITVAL_ASDF_CHECK_EN
      mismatch = mismatch | (asdf[2:0] !== 3'b111) | (asdf[3] !== bar_prev_q[3]);
`endif
   end

`ifndef INITVAL_ASDF_CHECK_EN
   // asdf stays on the interface but carries no checked information in this build.
   logic asdf_unused;
   assign asdf_unused = ^asdf;
`endif

   // Saturating error count and first-failure index for the current RUN cycle.
   always_comb begin
      err_d   = err_q;
      first_d = first_q;
      if ((state_q == RUN) && mismatch) begin
         if (err_q != CNT_MAX) begin
            err_d = err_q + 1'b1;
         end
         if (first_q == CNT_MAX) begin
            first_d = idx_q;
         end
      end
   end

   // Run sequencer with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         err_q   <= '0;
         first_q <= CNT_MAX;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= WARM;
                  busy_q  <= 1'b1;
                  err_q   <= '0;
                  first_q <= CNT_MAX;
                  pass_q  <= 1'b0;
               end
            end
            // One unchecked cycle primes the DUT's reset-less register.
            WARM: begin
               state_q <= RUN;
               idx_q   <= '0;
            end
            RUN: begin
               err_q   <= err_d;
               first_q <= first_d;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  // Uses err_d so an error in the final vector is reflected.
                  pass_q  <= (err_d == '0);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Previous-cycle stimulus, the reference for the DUT's registered half.
   always_ff @(posedge clk) begin
      if (rst) begin
         bar_prev_q <= 4'h0;
      end else begin
         bar_prev_q <= bar;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;

endmodule : initval_stim_checker
`default_nettype wire

// File: tb/tb_initval_stim_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_initval_stim_checker                                    |
// | Description : Self-checking bench: a behavioural nibble DUT with fault   |
// |               injection feeds the checker; expected results come from   |
// |               the LFSR sequence and the foo/asdf rules. Honours          |
// |               INITVAL_ASDF_CHECK_EN when predicting asdf faults.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_initval_stim_checker;

   localparam int NV   = 16;
   localparam int SNV  = 3;
   localparam int HOLD = 38;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] bar, foo, asdf;
   logic       busy, done, pass;
   logic [7:0] err_count, first_err_idx;

   logic       start_s = 1'b0;
   logic [3:0] bar_s;
   logic [3:0] foo_s = 4'h0;
   logic [3:0] asdf_s = 4'h0;
   logic       busy_s, done_s, pass_s;
   logic [1:0] err_s, first_s;

   logic [3:0] tb_prev = 4'h0;
   int         fault_mode = 0;
   logic [3:0] cmask = 4'h0;
   logic       asdf_fault = 1'b0;

   int         checks = 0;
   int         errors = 0;

   logic [3:0] seq    [0:NV];
   logic [3:0] cm_tab [0:NV-1];

   always #5 clk = ~clk;

   function automatic logic [3:0] fault_fn(input int mode, input logic [3:0] v);
      case (mode)
         1:       return v & 4'b1011;
         2:       return 4'h0;
         default: return v;
      endcase
   endfunction

   // Behavioural nibble DUT: upper half registered (no reset), lower half pass-through.
   always @(posedge clk) tb_prev <= bar;
   assign foo  = fault_fn(fault_mode, {tb_prev[3:2], bar[1:0]}) ^ cmask;
   assign asdf = {tb_prev[3], 2'b11, ~asdf_fault};

   initval_stim_checker #(.NUM_VECTORS(NV), .LFSR_SEED(4'h9), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .bar(bar), .foo(foo), .asdf(asdf),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_idx(first_err_idx)
   );

   initval_stim_checker #(.NUM_VECTORS(SNV), .LFSR_SEED(4'h9), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .bar(bar_s), .foo(foo_s), .asdf(asdf_s),
      .busy(busy_s), .done(done_s), .pass(pass_s),
      .err_count(err_s), .first_err_idx(first_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outcome of one run from the vector list and the response rules.
   task automatic model_run(input int mode, input logic af,
                            output int exp_err, output int exp_first, output logic exp_pass);
      int n;
      int first;
      logic [3:0] ideal;
      logic mm;
      n = 0;
      first = -1;
      for (int k = 0; k < NV; k++) begin
         ideal = {seq[k][3:2], seq[k+1][1:0]};
         mm = ((fault_fn(mode, ideal) ^ cm_tab[k]) != ideal);
`ifdef INITVAL_ASDF_CHECK_EN
         mm = mm | af;
`else
         mm = mm | (af & 1'b0);
`endif
         if (mm) begin
            if (first < 0) first = k;
            n++;
         end
      end
      exp_err   = (n > 255) ? 255 : n;
      exp_first = (first < 0) ? 255 : first;
      exp_pass  = (n == 0);
   endtask

   // One complete run from IDLE, checked cycle by cycle.
   task automatic do_run(input int mode, input logic af, input logic rnd);
      int   e_err, e_first;
      logic e_pass;
      fault_mode = mode;
      asdf_fault = af;
      for (int k = 0; k < NV; k++)
         cm_tab[k] = (rnd && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      model_run(mode, af, e_err, e_first, e_pass);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      start = 1'b1;
      cmask = 4'h0;
      @(negedge clk);
      start = 1'b0;
      chk("warm_bar", bar, seq[0]);
      chk("warm_busy", busy, 1);
      chk("warm_err_clr", err_count, 0);
      chk("warm_first_clr", first_err_idx, 8'hFF);
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         cmask = cm_tab[k];
         chk("run_bar", bar, seq[k+1]);
         chk("run_busy_done", {busy, done}, 2'b10);
      end
      @(negedge clk);
      cmask = 4'h0;
      chk("done_pulse", {busy, done}, 2'b01);
      chk("done_bar", bar, 0);
      chk("done_pass", pass, e_pass);
      chk("done_err", err_count, e_err);
      chk("done_first", first_err_idx, e_first);
      @(negedge clk);
      chk("idle_done_low", done, 0);
      chk("idle_pass_hold", pass, e_pass);
      chk("idle_err_hold", err_count, e_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   e_err, dones, n_s, first_s_exp;
      logic [3:0] ideal;
      logic [1:0] bd;

      seq[0] = 4'h9;
      for (int j = 0; j < NV; j++)
         seq[j+1] = {seq[j][2:0], seq[j][3] ^ seq[j][2]};
      for (int k = 0; k < NV; k++) cm_tab[k] = 4'h0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_bar", bar, 0);
      chk("rst_busy_done_pass", {busy, done, pass}, 3'b000);
      chk("rst_err", err_count, 0);
      chk("rst_first", first_err_idx, 8'hFF);
      chk("rst_s_first", first_s, 2'b11);
      rst = 1'b0;

      // Ideal, stuck foo[2], foo forced 0, asdf[0] forced 0, then random corruption
      do_run(0, 1'b0, 1'b0);
      do_run(1, 1'b0, 1'b0);
      do_run(2, 1'b0, 1'b0);
      do_run(0, 1'b1, 1'b0);
      do_run(0, 1'b0, 1'b0);
      for (int r = 0; r < 5; r++) do_run(0, 1'b0, 1'b1);

      // Reset in the middle of a failing run
      fault_mode = 2;
      for (int k = 0; k < NV; k++) cm_tab[k] = 4'h0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= 5; k++) @(negedge clk);
      e_err = 0;
      for (int k = 0; k < 5; k++)
         if ({seq[k][3:2], seq[k+1][1:0]} != 4'h0) e_err++;
      chk("mid_err_before_rst", err_count, e_err);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy_done", {busy, done}, 2'b00);
      chk("mid_rst_bar", bar, 0);
      chk("mid_rst_err", err_count, 0);
      chk("mid_rst_first", first_err_idx, 8'hFF);
      dones = 0;
      for (int t = 0; t < 24; t++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("mid_rst_no_done", dones, 0);
      chk("mid_rst_idle", busy, 0);
      do_run(0, 1'b0, 1'b0);

      // start held high: one run per IDLE entry
      fault_mode = 0;
      dones = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         start = (t < HOLD);
         bd = (t < HOLD && (t % 19) >= 1 && (t % 19) <= 17) ? 2'b10 :
              (t < HOLD && (t % 19) == 18) ? 2'b01 : 2'b00;
         chk("hold_busy_done", {busy, done}, bd);
         if (t < HOLD && (t % 19) == 1) chk("hold_warm_bar", bar, seq[0]);
         if (done) dones++;
      end
      start = 1'b0;
      chk("hold_done_count", dones, 2);
      chk("hold_pass", pass, 1);

      // Narrow counter, every response wrong
      n_s = 0;
      first_s_exp = 3;
      for (int k = 0; k < SNV; k++) begin
         ideal = {seq[k][3:2], seq[k+1][1:0]};
         if (ideal != 4'h0) begin
            if (first_s_exp == 3) first_s_exp = k;
            n_s++;
         end
      end
      if (n_s > 3) n_s = 3;
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      chk("s_warm_bar", bar_s, seq[0]);
      for (int k = 0; k < SNV; k++) @(negedge clk);
      @(negedge clk);
      chk("s_done", done_s, 1);
      chk("s_err_sat", err_s, n_s);
      chk("s_first", first_s, first_s_exp);
      chk("s_pass", pass_s, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_initval_stim_checker
`default_nettype wire
